bsn_frame_loader: RTL
=====================

# bsn_frame_loader

Framing stage that sits directly upstream of the bitonic sorting network and consumes its result. It collects up to NUM serial W-bit keys over a valid/ready stream and presents them as one parallel frame plus the sort direction to the network. After a fixed network latency it captures the sorted vector and streams it back out in slot order, so the scheduler core sees sorted keys as a serial stream.

## Interface
- NUM, 4: keys per frame; power of two, at least 4; must match the network's NUM.
- W, 16: key width in bits; must match the network's W.
- LAT, 2: cycles from a stable network input to a valid network output; at least 1.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- dir_in  in  1  requested sort direction (1 = ascending); sampled on a frame's first accepted beat.
- s_valid  in  1  upstream key valid.
- s_ready  out  1  loader accepts a key.
- s_data  in  W  key.
- s_last  in  1  last key of the frame.
- net_in  out  NUM*W  frame to the network; slot k is net_in[k*W +: W].
- net_dir  out  1  direction to the network.
- net_out  in  NUM*W  sorted vector from the network.
- m_valid  out  1  sorted key valid.
- m_ready  in  1  downstream accepts.
- m_data  out  W  sorted key.
- m_last  out  1  last real key of the frame.

## Operation
- States: FILL, WAIT, DRAIN. Reset enters FILL.
- Reset values: s_ready=1, m_valid=0, m_last=0, m_data=0, net_in=0, net_dir=0, all counters 0.
- **FILL**
  - s_ready=1. A beat is accepted when s_valid && s_ready.
  - Beat i writes slot i.
  - On the first beat (i=0), dir_in is latched into net_dir.
  - The frame closes on an accepted beat with s_last=1, or on the NUM-th beat regardless of s_last.
  - Real-key count cnt (1..NUM) is recorded.
  - Unfilled slots are written with a pad: all-ones if ascending, all-zeros if descending. Pads therefore sort to the tail.
  - On close: go to WAIT and clear the wait counter.
- **WAIT**
  - s_ready=0; net_in and net_dir are held stable.
  - The wait counter increments each cycle. When it reaches LAT-1, net_out is captured into the output buffer on that edge, and the state moves to DRAIN with ptr=0.
- **DRAIN**
  - m_valid=1; m_data = buffer slot ptr; m_last = (ptr == cnt-1).
  - On m_valid && m_ready, ptr increments.
  - On the handshake with m_last=1, the state returns to FILL, slot index is set to 0, and m_valid drops next cycle.
  - Pad slots are never emitted.
- Keys equal to the pad value are legal. Ties with pads are harmless because exactly cnt keys are emitted.
- s_valid while s_ready=0 is ignored and no data is taken. s_last on a FILL cycle with s_valid=0 has no effect.
- Reset asserted in any state: immediately returns to reset values. Any partial frame or undrained output is discarded.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- Frame-closing beat accepted at edge E:
  - s_ready=0 from E.
  - net_in is complete and stable from E.
  - Capture occurs at edge E+LAT.
  - m_valid=1 from E+LAT.
- The first output beat is therefore available LAT cycles after the closing beat.
- Drain rate is one key per cycle under continuous m_ready.
- After the m_last handshake at edge D, s_ready=1 from D. The next frame's first beat can be accepted at D+1.
- Frames do not overlap. Minimum period is cnt + LAT + cnt cycles.
- net_dir changes only at a frame's first accepted beat.

## Structure
- Shared package bsn_pkg:
  - state enum {FILL, WAIT, DRAIN};
  - localparam IDXW = $clog2(NUM) and LATW = $clog2(LAT+1);
  - function pad_key(dir) returning the W-bit pad.
- No sub-module. Slot registers, output buffer, ptr, wait counter and FSM live in one module.
- The bench instantiates bsn_frame_loader in front of BitonicNetwork (NUM=4, W=16) with LAT set to the network's latency.

## Test plan
- Full ascending frame: keys 9,3,7,1, dir_in=1, s_last on beat 4 → net_in slots 9,3,7,1; after LAT cycles stream is 1,3,7,9 with m_last on 9.
- Short descending frame: keys 5,12, s_last on beat 2, dir_in=0 → pads 0x0000 in slots 2–3; output 12,5 only, m_last on 5.
- Implied close: 4 beats with s_last=0 → frame closes; s_ready=0 next cycle; a fifth s_valid is not accepted until drain completes.
- Backpressure: m_ready toggling 1,0,0,1,1,0,1 during drain → each key is held stable while m_ready=0; no key is lost or duplicated.
- Reset mid-DRAIN after 2 of 4 keys → m_valid=0 and s_ready=1 immediately. The next frame 4,4,2,8 ascending yields 2,4,4,8.
- Back-to-back frames with dir 1 then 0 → net_dir changes only at the second frame's first beat; both outputs are correctly ordered.

Source files
------------

// File: rtl/bsn_frame_loader_pkg.sv
// Shared definitions for the bitonic-sort framing stage.
//   state_e  : loader FSM states (FILL, WAIT, DRAIN)
//   *_DEF    : default frame geometry matching the sorting network build
//   IDXW     : slot index width for the default key count
//   LATW     : wait counter width for the default network latency
//   pad_key  : filler key for unused slots; chosen so pads sort to the tail
package bsn_pkg;

  localparam int NUM_DEF = 4;
  localparam int W_DEF   = 16;
  localparam int LAT_DEF = 2;

  localparam int IDXW = $clog2(NUM_DEF);
  localparam int LATW = $clog2(LAT_DEF + 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Ascending frames pad with all-ones, descending with all-zeros, so a pad
  // never sorts ahead of a real key.
  function automatic logic [W_DEF-1:0] pad_key(input logic dir);
    return {W_DEF{dir}};
  endfunction

endpackage

// File: rtl/bsn_frame_loader.sv
// Framing stage in front of the bitonic sorting network.
// Collects up to NUM serial keys into a parallel frame, holds it on the
// network input for LAT cycles, captures the sorted vector and streams the
// real keys back out in slot order.
//
// Ports
//   clk, rst         : clock, asynchronous active-low reset
//   dir_in           : sort direction (1 = ascending), taken on a frame's first beat
//   s_valid/s_ready  : input key stream handshake
//   s_data, s_last   : input key and end-of-frame marker
//   net_in, net_dir  : frame and direction presented to the network
//   net_out          : sorted vector returned by the network
//   m_valid/m_ready  : sorted key stream handshake
//   m_data, m_last   : sorted key and last-real-key marker
//
// state | meaning
// ------+----------------------------------------------------------------
// FILL  | accepting keys into slots; closes on s_last or the NUM-th beat
// WAIT  | frame held on the network input while the result settles
// DRAIN | emitting the cnt real keys of the captured result
module bsn_frame_loader
  import bsn_pkg::*;
#(
  parameter int NUM = NUM_DEF,
  parameter int W   = W_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             s_last,
  output logic [NUM*W-1:0] net_in,
  output logic             net_dir,
  input  logic [NUM*W-1:0] net_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_data,
  output logic             m_last
);

  localparam int L_IDXW = $clog2(NUM);
  localparam int L_LATW = $clog2(LAT + 1);

  localparam logic [1:0] ST_FILL  = FILL;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        r_state;
  logic [W-1:0]      r_slot [NUM];
  logic [W-1:0]      r_buf  [NUM];
  logic [L_IDXW-1:0] r_idx;
  logic [L_IDXW-1:0] r_ptr;
  logic [L_IDXW:0]   r_cnt;
  logic [L_LATW-1:0] r_wcnt;
  logic              r_dir;
  logic              r_s_ready;
  logic              r_m_valid;
  logic              r_m_last;
  logic [W-1:0]      r_m_data;

  logic              w_beat;
  logic              w_close;
  logic              w_dir;
  logic [W-1:0]      w_pad;
  logic              w_hs;
  logic [L_IDXW-1:0] w_ptr_nxt;
  logic [L_IDXW:0]   w_cnt_m1;
  logic [W-1:0]      w_net_slot [NUM];

  assign w_beat    = s_valid && r_s_ready && (r_state == ST_FILL);
  assign w_close   = w_beat && (s_last || (r_idx == L_IDXW'(NUM - 1)));
  // The closing beat may also be the first beat, in which case the direction
  // has not been registered yet.
  assign w_dir     = (r_idx == '0) ? dir_in : r_dir;
  assign w_pad     = {W{w_dir}};
  assign w_hs      = r_m_valid && m_ready;
  assign w_ptr_nxt = r_ptr + L_IDXW'(1);
  assign w_cnt_m1  = r_cnt - (L_IDXW + 1)'(1);

  for (genvar g = 0; g < NUM; g++) begin : g_slot
    assign net_in[g*W +: W] = r_slot[g];
    assign w_net_slot[g]    = net_out[g*W +: W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_FILL;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_wcnt    <= '0;
      r_dir     <= 1'b0;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      for (int k = 0; k < NUM; k++) begin
        r_slot[k] <= '0;
        r_buf[k]  <= '0;
      end
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_beat) begin
            if (r_idx == '0) begin
              r_dir <= dir_in;
            end
            for (int k = 0; k < NUM; k++) begin
              if (L_IDXW'(k) == r_idx) begin
                r_slot[k] <= s_data;
              end else if (w_close && (L_IDXW'(k) > r_idx)) begin
                r_slot[k] <= w_pad;
              end
            end
            if (w_close) begin
              r_cnt     <= {1'b0, r_idx} + (L_IDXW + 1)'(1);
              r_wcnt    <= '0;
              r_s_ready <= 1'b0;
              r_state   <= ST_WAIT;
            end else begin
              r_idx <= r_idx + L_IDXW'(1);
            end
          end
        end

        ST_WAIT: begin
          if (r_wcnt == L_LATW'(LAT - 1)) begin
            for (int k = 0; k < NUM; k++) begin
              r_buf[k] <= w_net_slot[k];
            end
            // Output registers are loaded straight from the network so the
            // first key is valid on the capture edge itself.
            r_m_data  <= w_net_slot[0];
            r_m_last  <= (r_cnt == (L_IDXW + 1)'(1));
            r_m_valid <= 1'b1;
            r_ptr     <= '0;
            r_state   <= ST_DRAIN;
          end else begin
            r_wcnt <= r_wcnt + L_LATW'(1);
          end
        end

        ST_DRAIN: begin
          if (w_hs) begin
            if (r_m_last) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_s_ready <= 1'b1;
              r_idx     <= '0;
              r_ptr     <= '0;
              r_state   <= ST_FILL;
            end else begin
              r_ptr    <= w_ptr_nxt;
              r_m_data <= r_buf[w_ptr_nxt];
              r_m_last <= ({1'b0, w_ptr_nxt} == w_cnt_m1);
            end
          end
        end

        default: begin
          r_state   <= ST_FILL;
          r_idx     <= '0;
          r_s_ready <= 1'b1;
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign net_dir = r_dir;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;

endmodule
